// File: rtl/noc_link_arbiter.sv
// Packet-granular round-robin arbiter that shares one credit-flow-controlled NoC link
// among NUM_REQ requesters; enable/data are registered, grant is combinational.
module noc_link_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  enable,
  output logic [15:0]           data,
  input  logic                  credit,
  output logic [CNT_W-1:0]      credit_cnt,
  output logic                  credit_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                enable_q, enable_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    credit_cnt_q, credit_cnt_d;
  logic                credit_err_q, credit_err_d;

  logic [PTR_W-1:0]    idx_c;
  logic [PTR_W-1:0]    winner_c;
  logic                found_c;
  logic [PTR_W-1:0]    sel_c;
  logic                accept_c;
  logic                has_credit_c;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search from rr_ptr; descending loop leaves the nearest requester.
  always_comb begin
    idx_c    = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_c = PTR_W'((32'(rr_ptr_q) + 32'(off)) % NUM_REQ);
      if (req[idx_c]) begin
        winner_c = idx_c;
        found_c  = 1'b1;
      end
    end
  end

  // Next-state, accept and credit bookkeeping.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    sel_c        = winner_c;
    accept_c     = 1'b0;
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    has_credit_c = (credit_cnt_q != '0);

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (found_c && has_credit_c) begin
            accept_c = 1'b1;
            if (req_last[winner_c]) begin
              rr_ptr_d = inc_ptr(winner_c);
            end else begin
              owner_d = winner_c;
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          sel_c = owner_q;
          if (req[owner_q] && has_credit_c) begin
            accept_c = 1'b1;
            if (req_last[owner_q]) begin
              state_d  = IDLE;
              rr_ptr_d = inc_ptr(owner_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    grant    = accept_c ? (NUM_REQ'(1) << sel_c) : '0;
    enable_d = accept_c;
    data_d   = accept_c ? req_data[32'(sel_c)*DATA_W +: DATA_W] : data_q;

    // Simultaneous accept and credit return cancel out; overflow saturates and flags.
    case ({accept_c, credit})
      2'b10: credit_cnt_d = credit_cnt_q - 1'b1;
      2'b01: begin
        if (credit_cnt_q == CNT_MAX) credit_err_d = 1'b1;
        else                         credit_cnt_d = credit_cnt_q + 1'b1;
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      enable_q     <= 1'b0;
      data_q       <= '0;
      credit_cnt_q <= CNT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      enable_q     <= enable_d;
      data_q       <= data_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign enable     = enable_q;
  assign data       = data_q;
  assign credit_cnt = credit_cnt_q;
  assign credit_err = credit_err_q;

endmodule
